// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped 4-digit 7-segment scan controller with blanking gaps between digits.
// Optional register readback port is enabled with SEG7_READBACK_EN.
module seg7_scan_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0010,
  parameter logic [15:0] SCAN_DIV   = 16'd50000,
  parameter logic [7:0]  GAP_CYCLES = 8'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [6:0]  led_out,
  output logic [3:0]  an_out
`ifdef SEG7_READBACK_EN
  ,
  output logic [31:0] rdata
`endif
);

  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;
  localparam logic [15:0] DRIVE_LAST = SCAN_DIV - 16'd1;
  localparam logic [15:0] GAP_LAST = {8'h00, GAP_CYCLES - 8'd1};

  typedef enum logic [1:0] {OFF, DRIVE, GAP} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] cnt;
  logic [15:0] data_reg;
  logic        enable;
  logic [3:0]  mask;
  logic [1:0]  idx_next;
  logic        unused_wdata;

  assign idx_next = idx + 2'd1;
  assign unused_wdata = ^wdata[31:16];

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // A masked digit still occupies its slot, just with everything dark.
  function automatic logic [3:0] digit_an(input logic [1:0] i, input logic [3:0] m);
    digit_an = m[i] ? ~(4'b0001 << i) : 4'hF;
  endfunction

  function automatic logic [6:0] digit_led(input logic [1:0] i, input logic [3:0] m,
                                           input logic [15:0] d);
    digit_led = m[i] ? decode(d[{i, 2'b00} +: 4]) : 7'h7F;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= 16'h0000;
      enable   <= 1'b1;
      mask     <= 4'hF;
    end else if (we) begin
      if (addr == BASE_ADDR) begin
        data_reg <= wdata[15:0];
      end else if (addr == CTRL_ADDR) begin
        enable <= wdata[0];
        mask   <= wdata[7:4];
      end
    end
  end

  // Outputs are registered alongside the state, so each branch loads the
  // values belonging to the state it is entering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OFF;
      idx     <= 2'd0;
      cnt     <= 16'd0;
      an_out  <= 4'hF;
      led_out <= 7'h7F;
    end else if (!enable) begin
      state   <= OFF;
      idx     <= 2'd0;
      cnt     <= 16'd0;
      an_out  <= 4'hF;
      led_out <= 7'h7F;
    end else begin
      case (state)
        OFF: begin
          state   <= DRIVE;
          idx     <= 2'd0;
          cnt     <= 16'd0;
          an_out  <= digit_an(2'd0, mask);
          led_out <= digit_led(2'd0, mask, data_reg);
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            cnt <= 16'd0;
            if (GAP_CYCLES == 8'd0) begin
              state   <= DRIVE;
              idx     <= idx_next;
              an_out  <= digit_an(idx_next, mask);
              led_out <= digit_led(idx_next, mask, data_reg);
            end else begin
              state   <= GAP;
              an_out  <= 4'hF;
              led_out <= 7'h7F;
            end
          end else begin
            cnt     <= cnt + 16'd1;
            an_out  <= digit_an(idx, mask);
            led_out <= digit_led(idx, mask, data_reg);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state   <= DRIVE;
            idx     <= idx_next;
            cnt     <= 16'd0;
            an_out  <= digit_an(idx_next, mask);
            led_out <= digit_led(idx_next, mask, data_reg);
          end else begin
            cnt     <= cnt + 16'd1;
            an_out  <= 4'hF;
            led_out <= 7'h7F;
          end
        end
        default: begin
          state   <= OFF;
          idx     <= 2'd0;
          cnt     <= 16'd0;
          an_out  <= 4'hF;
          led_out <= 7'h7F;
        end
      endcase
    end
  end

`ifdef SEG7_READBACK_EN
  always_comb begin
    rdata = 32'h0000_0000;
    if (addr == BASE_ADDR) begin
      rdata = {16'h0000, data_reg};
    end else if (addr == CTRL_ADDR) begin
      rdata = {24'h00_0000, mask, 3'b000, enable};
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl: a frame-position model predicts every output cycle,
// with literal checks pinning the model. Readback checks compile in with SEG7_READBACK_EN.
module tb_seg7_scan_ctrl;

  localparam logic [31:0] BASE   = 32'h4000_0010;
  localparam logic [31:0] CTRL_A = BASE + 32'd4;
  localparam int DIV   = 4;
  localparam int GAP   = 1;
  localparam int SLOT  = DIV + GAP;
  localparam int FRAME = 4 * SLOT;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [6:0]  led_out;
  logic [3:0]  an_out;
`ifdef SEG7_READBACK_EN
  logic [31:0] rdata;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] m_data;
  logic        m_en;
  logic [3:0]  m_mask;
  bit          m_run;
  int          m_pos;
  logic [3:0]  exp_an;
  logic [6:0]  exp_led;
  bit          check_en;

  seg7_scan_ctrl #(
    .BASE_ADDR (BASE),
    .SCAN_DIV  (16'd4),
    .GAP_CYCLES(8'd1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .led_out(led_out),
`ifdef SEG7_READBACK_EN
    .an_out (an_out),
    .rdata  (rdata)
`else
    .an_out (an_out)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 16'h0000;
    m_en   = 1'b1;
    m_mask = 4'hF;
    m_run  = 1'b0;
    m_pos  = 0;
  endtask

  // The scan is a fixed 20-cycle frame; position within it picks digit and drive/gap.
  task automatic model_step();
    int d;
    logic [15:0] sh;
    if (!m_en) begin
      m_run = 1'b0;
      m_pos = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
    exp_an  = 4'hF;
    exp_led = 7'h7F;
    if (m_run) begin
      d = m_pos / SLOT;
      if ((m_pos % SLOT) < DIV && m_mask[d]) begin
        exp_an  = 4'hF ^ (4'b0001 << d);
        sh      = m_data >> (4 * d);
        exp_led = seg_tab[sh[3:0]];
      end
    end
    if (we && addr == BASE) begin
      m_data = wdata[15:0];
    end else if (we && addr == CTRL_A) begin
      m_en   = wdata[0];
      m_mask = wdata[7:4];
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      model_step();
      #1;
      if (check_en) begin
        check_output("model_an", {28'h0, an_out}, {28'h0, exp_an});
        check_output("model_led", {25'h0, led_out}, {25'h0, exp_led});
      end
    end
  end

  task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic pin_outputs(input string name, input logic [3:0] an_exp,
                             input logic [6:0] led_exp);
    check_output({name, "_an"}, {28'h0, an_out}, {28'h0, an_exp});
    check_output({name, "_led"}, {25'h0, led_out}, {25'h0, led_exp});
  endtask

  logic [3:0] seq_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seq_led [4] = '{7'h40, 7'h79, 7'h08, 7'h00};
  logic [3:0] msk_an  [4] = '{4'hE, 4'hF, 4'hB, 4'hF};
  logic [6:0] msk_led [4] = '{7'h40, 7'h7F, 7'h08, 7'h7F};

  initial begin
    we       = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    check_en = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 pin_outputs("reset", 4'hF, 7'h7F);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;
    #1 pin_outputs("release", 4'hF, 7'h7F);
    @(posedge clk); #2;
    pin_outputs("first_edge", 4'hE, 7'h40);
    repeat (4) @(posedge clk); #2;
    pin_outputs("first_gap", 4'hF, 7'h7F);

    // Restart the scan so slot positions are known, then walk the frame.
    apply_stimulus(1'b1, BASE, 32'hFFFF_8A10);
    apply_stimulus(1'b1, CTRL_A, 32'h0);
    apply_stimulus(1'b1, CTRL_A, 32'hF1);
    @(posedge clk); #2;
    pin_outputs("slot0", seq_an[0], seq_led[0]);
    for (int k = 1; k < 5; k++) begin
      repeat (SLOT) @(posedge clk); #2;
      pin_outputs($sformatf("slot%0d", k), seq_an[k % 4], seq_led[k % 4]);
    end

    apply_stimulus(1'b1, CTRL_A, 32'h0);
    apply_stimulus(1'b1, CTRL_A, 32'h51);
    @(posedge clk); #2;
    pin_outputs("mask0", msk_an[0], msk_led[0]);
    for (int k = 1; k < 5; k++) begin
      repeat (SLOT) @(posedge clk); #2;
      pin_outputs($sformatf("mask%0d", k), msk_an[k % 4], msk_led[k % 4]);
    end

    // Disable while digit 2 is being driven, then re-enable.
    apply_stimulus(1'b1, CTRL_A, 32'h0);
    apply_stimulus(1'b1, CTRL_A, 32'hF1);
    repeat (11) @(posedge clk);
    apply_stimulus(1'b1, CTRL_A, 32'h0);
    @(posedge clk); #2;
    pin_outputs("disable", 4'hF, 7'h7F);
    repeat (3) @(posedge clk); #2;
    pin_outputs("disable_held", 4'hF, 7'h7F);
    apply_stimulus(1'b1, CTRL_A, 32'hF1);
    @(posedge clk); #2;
    pin_outputs("reenable", 4'hE, 7'h40);

    apply_stimulus(1'b1, BASE + 32'd8, 32'h0000_FFFF);
    apply_stimulus(1'b0, BASE, 32'h0000_7777);
    repeat (FRAME) @(negedge clk);

`ifdef SEG7_READBACK_EN
    apply_stimulus(1'b1, BASE, 32'h0000_1234);
    apply_stimulus(1'b1, CTRL_A, 32'h31);
    addr = BASE;
    #1 check_output("rdata_data", rdata, 32'h0000_1234);
    addr = CTRL_A;
    #1 check_output("rdata_ctrl", rdata, 32'h0000_0031);
    addr = BASE + 32'd8;
    #1 check_output("rdata_other", rdata, 32'h0);
`endif

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 250; i++) begin
        case ($urandom_range(0, 5))
          0: begin
            apply_stimulus(1'b1, BASE, $urandom());
`ifdef SEG7_READBACK_EN
            #1 check_output("rdata_rand", rdata, {16'h0, m_data});
`endif
          end
          1: apply_stimulus(1'b1, CTRL_A,
                            {$urandom_range(0, 32'h7FFF_FFFF), ($urandom_range(0, 3) != 0)});
          2: apply_stimulus(1'b1, BASE + 32'd8, $urandom());
          3: apply_stimulus(1'b0, ($urandom_range(0, 1) != 0) ? BASE : CTRL_A, $urandom());
          default: repeat ($urandom_range(1, 12)) @(negedge clk);
        endcase
      end
      if (pass == 0) begin
        // Asynchronous reset in the middle of a cycle blanks outputs at once.
        @(negedge clk); #2;
        rst_n    = 1'b0;
        check_en = 1'b0;
        model_reset();
        #1 pin_outputs("midscan_reset", 4'hF, 7'h7F);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;
        @(posedge clk); #2;
        pin_outputs("restart", 4'hE, 7'h40);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
